// File: rtl/window_mc_if.sv
// AXI-Stream style bundle used on both sides of window_mc.
//   tvalid : beat valid (master -> slave)
//   tready : slave can take the beat (slave -> master)
//   tdata  : W-bit payload, channels packed low to high
//   tlast  : last beat of a frame
// The design takes the slave modport on its input side and the master
// modport on its output side.
interface window_mc_if #(
    parameter int W = 64
) ();
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/window_mc.sv
// window_mc: multi-channel window multiplier for the ADC sample path.
// Every channel of a beat is multiplied by the coefficient stored at the
// beat's position in the frame, then rounded (half up) and shifted back by
// COEF_W-1 bits to OUT_W. Three-stage pipeline with a global stall enable.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   coef_we_i           coefficient write strobe
//   coef_waddr_i        coefficient write index (AW bits)
//   coef_wdata_i        coefficient value, signed Q1.(COEF_W-1)
//   bypass_i            unity-gain mode, latched at the first beat of a frame
//   s_axis (slave)      input sample stream, CHANNELS*DATA_W wide
//   m_axis (master)     output sample stream, CHANNELS*OUT_W wide
//   frame_err_o         sticky framing-error flag
//   frame_err_clr_i     clears frame_err_o (a same-cycle new error wins)
//
// Build option: define WINDOW_MC_SAT_EN to saturate the reduction to OUT_W;
// otherwise the result wraps to its low OUT_W bits.
module window_mc #(
    parameter int CHANNELS  = 4,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int OUT_W     = 16,
    parameter int FRAME_LEN = 2048,
    parameter int AW        = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_we_i,
    input  logic [AW-1:0]     coef_waddr_i,
    input  logic [COEF_W-1:0] coef_wdata_i,
    input  logic              bypass_i,
    window_mc_if.slave        s_axis,
    window_mc_if.master       m_axis,
    output logic              frame_err_o,
    input  logic              frame_err_clr_i
);
    localparam int P_W = DATA_W + COEF_W;
    localparam logic [AW-1:0]        IDX_LAST = AW'(FRAME_LEN - 1);
    localparam logic signed [P_W-1:0] RND     = P_W'(2 ** (COEF_W - 2));
`ifdef WINDOW_MC_SAT_EN
    localparam logic signed [P_W-1:0] Y_MAX = {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [P_W-1:0] Y_MIN = {{(P_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    logic en, hs, at_last, at_first;

    logic [AW-1:0] idx_q, idx_d;
    logic          byp_frame_q, byp_frame_d, byp_eff;
    logic          err_q, err_d, err_set;

    logic [COEF_W-1:0] ram [FRAME_LEN];
    logic [COEF_W-1:0] coef_q;
    logic [P_W-1:0]    ce;

    logic                       v1_q, last1_q, byp1_q;
    logic [CHANNELS*DATA_W-1:0] x1_q;
    logic                       v2_q, last2_q;
    logic [CHANNELS*P_W-1:0]    p2_q, p2_d;
    logic                       v3_q, last3_q;
    logic [CHANNELS*OUT_W-1:0]  y3_q, y3_d;

    // A full output register that is not being taken freezes the whole pipe.
    assign en            = !v3_q || m_axis.tready;
    assign s_axis.tready = en;
    assign hs            = s_axis.tvalid && en;

    assign at_last  = (idx_q == IDX_LAST);
    assign at_first = (idx_q == '0);

    always_comb begin
        idx_d = idx_q;
        if (hs) begin
            if (s_axis.tlast || at_last) idx_d = '0;
            else                         idx_d = idx_q + 1'b1;
        end
    end

    // tlast must coincide exactly with the last index; either mismatch is an error.
    assign err_set = hs && (s_axis.tlast ^ at_last);
    assign err_d   = err_set || (err_q && !frame_err_clr_i);

    // The first beat of a frame uses the live bypass input; later beats use the latch.
    assign byp_eff     = at_first ? bypass_i : byp_frame_q;
    assign byp_frame_d = (hs && at_first) ? bypass_i : byp_frame_q;

    // Coefficient RAM: write any time, read gated by en so a stall holds the
    // read data aligned with the held sample. Same-address read returns old data.
    always_ff @(posedge clk) begin
        if (coef_we_i) ram[coef_waddr_i] <= coef_wdata_i;
        if (en)        coef_q <= ram[idx_q];
    end

    assign ce = {{DATA_W{coef_q[COEF_W-1]}}, coef_q};

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [P_W-1:0] xe, prod, rnd, y_full;
        logic [OUT_W-1:0]      y_red;

        assign xe = {{COEF_W{x1_q[c*DATA_W+DATA_W-1]}}, x1_q[c*DATA_W +: DATA_W]};
        // Bypass pre-scales x by 2^(COEF_W-1) so the shared round/shift returns x exactly.
        assign prod = byp1_q ? (xe <<< (COEF_W - 1)) : (xe * $signed(ce));
        assign p2_d[c*P_W +: P_W] = prod;

        assign rnd    = $signed(p2_q[c*P_W +: P_W]) + RND;
        assign y_full = rnd >>> (COEF_W - 1);
`ifdef WINDOW_MC_SAT_EN
        assign y_red = (y_full > Y_MAX) ? Y_MAX[OUT_W-1:0] :
                       (y_full < Y_MIN) ? Y_MIN[OUT_W-1:0] : y_full[OUT_W-1:0];
`else
        logic unused_hi;
        assign unused_hi = ^y_full[P_W-1:OUT_W];
        assign y_red     = y_full[OUT_W-1:0];
`endif
        assign y3_d[c*OUT_W +: OUT_W] = y_red;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            byp_frame_q <= 1'b0;
            err_q       <= 1'b0;
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            byp1_q      <= 1'b0;
            x1_q        <= '0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            p2_q        <= '0;
            v3_q        <= 1'b0;
            last3_q     <= 1'b0;
            y3_q        <= '0;
        end else begin
            idx_q       <= idx_d;
            byp_frame_q <= byp_frame_d;
            err_q       <= err_d;
            if (en) begin
                v1_q    <= s_axis.tvalid;
                last1_q <= s_axis.tlast;
                byp1_q  <= byp_eff;
                x1_q    <= s_axis.tdata;
                v2_q    <= v1_q;
                last2_q <= last1_q;
                p2_q    <= p2_d;
                v3_q    <= v2_q;
                last3_q <= last2_q;
                y3_q    <= y3_d;
            end
        end
    end

    assign m_axis.tvalid = v3_q;
    assign m_axis.tdata  = y3_q;
    assign m_axis.tlast  = last3_q;
    assign frame_err_o   = err_q;
endmodule

// File: doc/window_mc.md
Name: window_mc

Overview:
- Parametrised multi-channel window multiplier for the ADC sample path. Sits between the ADC capture stream and the FFT/downstream processing.
- Multiplies each sample of a frame by a per-index coefficient held in an internal RAM, with a rounding shift to the output width.
- Unlike the previous generation it:
  - honours downstream backpressure;
  - tracks frame position itself and flags framing errors;
  - latches bypass mode per frame;
  - optionally saturates the output.

Parameters:
CHANNELS, 4, number of parallel channels packed in TDATA
DATA_W, 16, signed input sample width per channel
COEF_W, 16, signed coefficient width, format Q1.(COEF_W-1)
OUT_W, 16, signed output width per channel
FRAME_LEN, 2048, samples per frame; must be a power of two, 2..65536
AW, $clog2(FRAME_LEN), coefficient address width

Ports:
clk  input  1  single clock for all logic
rst  input  1  asynchronous active-high reset
coef_we  input  1  coefficient write strobe
coef_waddr  input  AW  coefficient write index
coef_wdata  input  COEF_W  coefficient value
bypass  input  1  1 = pass samples unwindowed (sampled at frame start)
s_axis_tvalid  input  1  input sample valid
s_axis_tready  output  1  block can accept a sample
s_axis_tdata  input  CHANNELS*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
s_axis_tlast  input  1  last sample of frame
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  downstream ready
m_axis_tdata  output  CHANNELS*OUT_W  channel i at bits [i*OUT_W +: OUT_W]
m_axis_tlast  output  1  last sample of frame (delayed s_axis_tlast)
frame_err  output  1  sticky framing-error flag
frame_err_clr  input  1  clears frame_err

Behaviour:
- Reset values:
  - all outputs 0, except s_axis_tready = 1;
  - frame index 0, pipeline valids 0, latched bypass 0, frame_err 0.
  - RAM contents are not reset.
- Pipeline: 3 stages.
  - S1: register sample and index; RAM synchronous read.
  - S2: multiply DATA_W x COEF_W, full-precision product.
  - S3: round and shift, register output.
- Stall rule:
  - All stages advance only when en = !m_axis_tvalid | m_axis_tready.
  - s_axis_tready = en, combinational from m_axis_tready; no skid buffer.
  - A stall holds every stage, including the RAM read (RAM enable = en).
- Latency: accepted sample appears on m_axis_tdata 3 en-cycles later. With tready held 1, throughput is 1 sample/cycle.
- AXIS output:
  - m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.
  - Bubbles propagate as tvalid=0 slots.
- Frame index:
  - Increments on each input handshake (tvalid & tready).
  - Returns to 0 after index FRAME_LEN-1, or after a handshake with s_axis_tlast=1, whichever comes first.
- frame_err is set (sticky) when either:
  - s_axis_tlast=1 at an index other than FRAME_LEN-1; or
  - index FRAME_LEN-1 is handshaken with s_axis_tlast=0.
- frame_err clear:
  - frame_err_clr clears it.
  - If clear and a new error occur in the same cycle, set wins.
- Bypass: sampled on the handshake of index 0 and held for the whole frame. Mid-frame toggles take effect at the next frame.
- Arithmetic, windowed mode:
  - p = x * c, signed, DATA_W+COEF_W bits.
  - y = (p + 2^(COEF_W-2)) >>> (COEF_W-1): round half up toward +inf.
  - Result then reduced to OUT_W bits (see Optional Feature).
- Arithmetic, bypass mode: y = x sign-extended or reduced to OUT_W through the same reduction path. The coefficient is ignored, so this is exact unity gain.
- Coefficient RAM:
  - FRAME_LEN x COEF_W, one write port and one read port, both on clk.
  - Writes are accepted at any time, including during streaming and during stall.
  - Read-during-write to the same address returns the old data.
  - A coef_waddr value >= FRAME_LEN cannot occur (AW-wide).
- Reset mid-frame: pipeline is flushed, in-flight samples are lost, index returns to 0, m_axis_tvalid drops asynchronously.

Optional Feature:
- Macro: WINDOW_MC_SAT_EN.
- Defined: the reduction to OUT_W saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: the reduction truncates to the low OUT_W bits (two's-complement wrap); no saturation logic is built.

Test Plan:
- Rounding and scaling. Config: CHANNELS=4, DATA_W=COEF_W=OUT_W=16, FRAME_LEN=8, coef[k]=0x4000 for all k, tready=1.
  - Samples 1000, -1000, 3, -3 -> outputs 500, -500, 2, -1.
  - First output appears exactly 3 cycles after the first handshake.
- Per-index window. coef[k]=k*0x1000, all channels x=0x0100, 8-sample frame.
  - Outputs 0x0000, 0x0020, 0x0040 … 0x00E0.
  - m_axis_tlast on the 8th output only.
  - Second frame identical.
- Backpressure. Random m_axis_tready (50%), 3 frames streamed.
  - No data lost or duplicated.
  - tdata/tlast stable while stalled.
  - s_axis_tready tracks en.
- Framing error. tlast asserted at index 5.
  - frame_err=1 and index restarts at 0.
  - frame_err_clr pulse clears it.
  - Frame with no tlast at index 7 sets it again.
- Bypass and saturation.
  - Bypass toggled at index 3: takes effect from the next frame, where output = input.
  - x=-32768, coef=0x8000 -> 32767 with WINDOW_MC_SAT_EN, -32768 without.
- Async reset mid-frame at index 4 with a stalled pipeline.
  - m_axis_tvalid=0 immediately.
  - After release, the first frame starts at coef[0] and frame_err=0.
